// File: rtl/branch_resolve_if.sv
// Handshake and payload bundle for the branch resolution stage:
// upstream issue, downstream result and fetch redirect.
interface branch_resolve_if;
   localparam int unsigned XLEN = 32;

   logic            in_valid;
   logic            in_ready;
   logic [1:0]      in_kind;
   logic [2:0]      in_funct3;
   logic [XLEN-1:0] in_pc;
   logic [XLEN-1:0] in_rs1;
   logic [XLEN-1:0] in_rs2;
   logic [XLEN-1:0] in_imm;

   logic            out_valid;
   logic            out_ready;
   logic            out_taken;
   logic [XLEN-1:0] out_target;
   logic [XLEN-1:0] out_link;
   logic            out_misaligned;
   logic            out_illegal;

   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   // Issue side plus downstream consumer
   modport master (
      output in_valid, in_kind, in_funct3, in_pc, in_rs1, in_rs2, in_imm, out_ready,
      input  in_ready, out_valid, out_taken, out_target, out_link, out_misaligned,
             out_illegal, redirect_valid, redirect_pc
   );

   // Branch resolution stage
   modport slave (
      input  in_valid, in_kind, in_funct3, in_pc, in_rs1, in_rs2, in_imm, out_ready,
      output in_ready, out_valid, out_taken, out_target, out_link, out_misaligned,
             out_illegal, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/branch_resolve.sv
// Execute-side branch/jump resolution: S1 captures operands, S2 holds the
// resolved result; taken, aligned transfers emit a one-cycle fetch redirect.
module branch_resolve #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned XLEN         = 32
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           flush,
   branch_resolve_if.slave bus
);

   typedef enum logic [1:0] {
      KIND_NONE = 2'b00,
      KIND_BR   = 2'b01,
      KIND_JAL  = 2'b10,
      KIND_JALR = 2'b11
   } kind_e;

   // S1 operand capture
   logic            s1_valid_q, s1_valid_d;
   kind_e           s1_kind_q;
   logic [2:0]      s1_funct3_q;
   logic [XLEN-1:0] s1_pc_q, s1_rs1_q, s1_rs2_q, s1_imm_q;

   // S2 result and redirect
   logic            out_valid_q, out_valid_d;
   logic            out_taken_q, out_misaligned_q, out_illegal_q;
   logic [XLEN-1:0] out_target_q, out_link_q;
   logic            redirect_valid_q, redirect_valid_d;
   logic [XLEN-1:0] redirect_pc_q;

   // S1 evaluation
   logic            cmp_less, cmp_sign, cmp_negate, cmp_raw, cmp_result;
   logic            s1_illegal, s1_taken, s1_misaligned, s1_taken_ok;
   logic [XLEN-1:0] s1_target, s1_link, pc_plus_imm, rs1_plus_imm;
   logic            advance, in_ready_c, accept;

   // Comparator select from funct3, comparator, and target/link resolution
   always_comb begin
      cmp_less     = s1_funct3_q[2];
      cmp_sign     = !s1_funct3_q[1];
      cmp_negate   = s1_funct3_q[0];
      cmp_raw      = 1'b0;
      if (cmp_less) begin
         if (cmp_sign) cmp_raw = $signed(s1_rs1_q) < $signed(s1_rs2_q);
         else          cmp_raw = s1_rs1_q < s1_rs2_q;
      end else begin
         cmp_raw = (s1_rs1_q == s1_rs2_q);
      end
      cmp_result   = cmp_raw ^ cmp_negate;

      pc_plus_imm  = s1_pc_q + s1_imm_q;
      rs1_plus_imm = s1_rs1_q + s1_imm_q;
      s1_link      = s1_pc_q + XLEN'(4);
      // funct3 010/011 have no branch encoding
      s1_illegal   = (s1_kind_q == KIND_BR) && (s1_funct3_q[2:1] == 2'b01);

      s1_taken  = 1'b0;
      s1_target = s1_link;
      case (s1_kind_q)
         KIND_BR: begin
            s1_taken  = cmp_result && !s1_illegal;
            s1_target = pc_plus_imm;
         end
         KIND_JAL: begin
            s1_taken  = 1'b1;
            s1_target = pc_plus_imm;
         end
         KIND_JALR: begin
            s1_taken  = 1'b1;
            s1_target = rs1_plus_imm & ~XLEN'(1);
         end
         default: begin
            s1_taken  = 1'b0;
            s1_target = s1_link;
         end
      endcase

      s1_misaligned = s1_taken && s1_target[1];
      s1_taken_ok   = s1_taken && !s1_misaligned;
   end

   // Handshake: a redirecting entry blocks capture of younger entries
   always_comb begin
      advance    = s1_valid_q && (!out_valid_q || bus.out_ready);
      in_ready_c = !redirect_valid_q && (!s1_valid_q || (advance && !s1_taken_ok));
      accept     = bus.in_valid && in_ready_c && !flush;
   end

   // Next-state for the valid bits; flush kills everything in flight
   always_comb begin
      s1_valid_d       = s1_valid_q;
      out_valid_d      = out_valid_q;
      redirect_valid_d = 1'b0;
      if (flush) begin
         s1_valid_d  = 1'b0;
         out_valid_d = 1'b0;
      end else begin
         if (advance)            out_valid_d = 1'b1;
         else if (bus.out_ready) out_valid_d = 1'b0;
         if (accept)             s1_valid_d  = 1'b1;
         else if (advance)       s1_valid_d  = 1'b0;
         redirect_valid_d = advance && s1_taken_ok;
      end
   end

   // Pipeline registers
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q       <= 1'b0;
         s1_kind_q        <= KIND_NONE;
         s1_funct3_q      <= 3'b000;
         s1_pc_q          <= '0;
         s1_rs1_q         <= '0;
         s1_rs2_q         <= '0;
         s1_imm_q         <= '0;
         out_valid_q      <= 1'b0;
         out_taken_q      <= 1'b0;
         out_misaligned_q <= 1'b0;
         out_illegal_q    <= 1'b0;
         out_target_q     <= XLEN'(RESET_VECTOR);
         out_link_q       <= XLEN'(RESET_VECTOR);
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= XLEN'(RESET_VECTOR);
      end else begin
         s1_valid_q       <= s1_valid_d;
         out_valid_q      <= out_valid_d;
         redirect_valid_q <= redirect_valid_d;
         if (accept) begin
            s1_kind_q   <= kind_e'(bus.in_kind);
            s1_funct3_q <= bus.in_funct3;
            s1_pc_q     <= bus.in_pc;
            s1_rs1_q    <= bus.in_rs1;
            s1_rs2_q    <= bus.in_rs2;
            s1_imm_q    <= bus.in_imm;
         end
         if (advance && !flush) begin
            out_taken_q      <= s1_taken;
            out_misaligned_q <= s1_misaligned;
            out_illegal_q    <= s1_illegal;
            out_target_q     <= s1_target;
            out_link_q       <= s1_link;
         end
         if (redirect_valid_d) redirect_pc_q <= s1_target;
      end
   end

   assign bus.in_ready       = in_ready_c;
   assign bus.out_valid      = out_valid_q;
   assign bus.out_taken      = out_taken_q;
   assign bus.out_target     = out_target_q;
   assign bus.out_link       = out_link_q;
   assign bus.out_misaligned = out_misaligned_q;
   assign bus.out_illegal    = out_illegal_q;
   assign bus.redirect_valid = redirect_valid_q;
   assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: directed entries push expected
// results and redirects; a monitor pops and compares on each output.
module tb_branch_resolve;

   typedef struct packed {
      logic        taken;
      logic [31:0] target;
      logic [31:0] link;
      logic        mis;
      logic        ill;
   } exp_t;

   logic clk;
   logic reset;
   logic flush;

   branch_resolve_if bus ();

   branch_resolve #(.RESET_VECTOR(32'h0000_0000), .XLEN(32)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   exp_t        exp_q[$];
   logic [31:0] redir_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event not expected by scoreboard", name);
   endtask

   // Drive one entry starting at a negedge; hold until accepted, return at a negedge
   task automatic send(input logic [1:0] k, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm,
                       input logic e_taken, input logic [31:0] e_target,
                       input logic e_mis, input logic e_ill, input logic e_redir,
                       input bit push, output int waits);
      exp_t e;
      bus.in_valid  = 1'b1;
      bus.in_kind   = k;
      bus.in_funct3 = f3;
      bus.in_pc     = pc;
      bus.in_rs1    = rs1;
      bus.in_rs2    = rs2;
      bus.in_imm    = imm;
      waits = 0;
      #1;
      while (!bus.in_ready && waits < 50) begin
         @(negedge clk);
         #1;
         waits++;
      end
      if (!bus.in_ready) begin
         fail_now("accept_timeout");
         bus.in_valid = 1'b0;
      end else if (push) begin
         e.taken  = e_taken;
         e.target = e_target;
         e.link   = pc + 32'd4;
         e.mis    = e_mis;
         e.ill    = e_ill;
         exp_q.push_back(e);
         if (e_redir) redir_q.push_back(e_target);
      end
      @(negedge clk);
   endtask

   // Output and redirect monitor
   initial begin
      exp_t e;
      logic [31:0] rp;
      forever begin
         @(negedge clk);
         #1;
         if (!reset && !flush && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) fail_now("unexpected_out");
            else begin
               e = exp_q.pop_front();
               chk("out_taken",      32'(bus.out_taken),      32'(e.taken));
               chk("out_target",     bus.out_target,          e.target);
               chk("out_link",       bus.out_link,            e.link);
               chk("out_misaligned", 32'(bus.out_misaligned), 32'(e.mis));
               chk("out_illegal",    32'(bus.out_illegal),    32'(e.ill));
            end
         end
         if (!reset && bus.redirect_valid) begin
            if (redir_q.size() == 0) fail_now("unexpected_redirect");
            else begin
               rp = redir_q.pop_front();
               chk("redirect_pc", bus.redirect_pc, rp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int w;
      reset          = 1'b1;
      flush          = 1'b0;
      bus.out_ready  = 1'b1;
      bus.in_valid   = 1'b1;
      bus.in_kind    = 2'b01;
      bus.in_funct3  = 3'b000;
      bus.in_pc      = 32'h0000_0040;
      bus.in_rs1     = 32'd0;
      bus.in_rs2     = 32'd0;
      bus.in_imm     = 32'h0000_0010;
      repeat (3) @(negedge clk);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      chk("rst_out_valid",   32'(bus.out_valid),      32'd0);
      chk("rst_redirect",    32'(bus.redirect_valid), 32'd0);
      chk("rst_out_target",  bus.out_target,          32'h0);
      chk("rst_out_link",    bus.out_link,            32'h0);
      chk("rst_redirect_pc", bus.redirect_pc,         32'h0);
      chk("rst_out_taken",   32'(bus.out_taken),      32'd0);
      chk("rst_in_ready",    32'(bus.in_ready),       32'd1);
      @(negedge clk);

      // BLT signed -1 < 1: taken, redirect
      send(2'b01, 3'b100, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 1, 32'h120, 0, 0, 1, 1, w);
      chk("blt_wait", 32'(w), 32'd0);
      // BLTU 0xFFFFFFFF < 1 false; held off through the redirect
      send(2'b01, 3'b110, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 0, 32'h120, 0, 0, 0, 1, w);
      chk("post_redirect_wait", 32'(w), 32'd2);
      // JALR clears bit0
      send(2'b11, 3'b000, 32'h300, 32'h1001, 32'd0, 32'd4, 1, 32'h1004, 0, 0, 1, 1, w);
      chk("jalr_wait", 32'(w), 32'd0);
      // JAL to bit1-set target: misaligned, no redirect
      send(2'b10, 3'b000, 32'h200, 32'd0, 32'd0, 32'd6, 1, 32'h206, 1, 0, 0, 1, w);
      chk("jal_after_jalr_wait", 32'(w), 32'd2);
      // Illegal funct3 010 (operands equal would otherwise match)
      send(2'b01, 3'b010, 32'h400, 32'd5, 32'd5, 32'h10, 0, 32'h410, 0, 1, 0, 1, w);
      chk("after_misaligned_wait", 32'(w), 32'd0);
      send(2'b01, 3'b011, 32'h404, 32'd1, 32'd2, 32'd8, 0, 32'h40C, 0, 1, 0, 1, w);
      // BEQ taken with address wrap-around
      send(2'b01, 3'b000, 32'hFFFF_FFFC, 32'd5, 32'd5, 32'd8, 1, 32'h4, 0, 0, 1, 1, w);
      // kind none
      send(2'b00, 3'b000, 32'h500, 32'd0, 32'd0, 32'h40, 0, 32'h504, 0, 0, 0, 1, w);
      chk("none_after_wrap_wait", 32'(w), 32'd2);
      // Back-to-back not-taken stream
      send(2'b01, 3'b000, 32'h600, 32'd1, 32'd2, 32'h10, 0, 32'h610, 0, 0, 0, 1, w);
      chk("stream0_wait", 32'(w), 32'd0);
      send(2'b01, 3'b001, 32'h604, 32'd3, 32'd3, 32'h10, 0, 32'h614, 0, 0, 0, 1, w);
      chk("stream1_wait", 32'(w), 32'd0);
      send(2'b01, 3'b101, 32'h608, 32'hFFFF_FFFF, 32'd0, 32'h10, 0, 32'h618, 0, 0, 0, 1, w);
      chk("stream2_wait", 32'(w), 32'd0);
      send(2'b01, 3'b111, 32'h60C, 32'd1, 32'd2, 32'h10, 0, 32'h61C, 0, 0, 0, 1, w);
      chk("stream3_wait", 32'(w), 32'd0);
      // Taken BGEU and BNE
      send(2'b01, 3'b111, 32'h610, 32'hFFFF_FFFF, 32'd1, 32'h40, 1, 32'h650, 0, 0, 1, 1, w);
      send(2'b01, 3'b001, 32'h614, 32'd7, 32'd8, 32'hFFFF_FFF0, 1, 32'h604, 0, 0, 1, 1, w);
      bus.in_valid = 1'b0;
      repeat (4) @(negedge clk);

      // Backpressure: S2 held, S1 fills, in_ready drops
      bus.out_ready = 1'b0;
      send(2'b01, 3'b000, 32'h700, 32'd1, 32'd2, 32'h10, 0, 32'h710, 0, 0, 0, 1, w);
      send(2'b01, 3'b000, 32'h704, 32'd1, 32'd2, 32'h10, 0, 32'h714, 0, 0, 0, 1, w);
      chk("bp_second_wait", 32'(w), 32'd0);
      bus.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_out_valid",  32'(bus.out_valid), 32'd1);
         chk("bp_out_target", bus.out_target,     32'h710);
         chk("bp_in_ready",   32'(bus.in_ready),  32'd0);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      repeat (4) @(negedge clk);

      // Flush with S2 (not taken) and S1 (taken) full: no redirect
      bus.out_ready = 1'b0;
      send(2'b01, 3'b000, 32'h800, 32'd1, 32'd2, 32'h10, 0, 32'h810, 0, 0, 0, 0, w);
      send(2'b01, 3'b000, 32'h900, 32'd5, 32'd5, 32'h20, 1, 32'h920, 0, 0, 0, 0, w);
      flush         = 1'b1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_pc     = 32'hA00;
      @(negedge clk);
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      chk("flush_out_valid", 32'(bus.out_valid),      32'd0);
      chk("flush_redirect",  32'(bus.redirect_valid), 32'd0);
      chk("flush_in_ready",  32'(bus.in_ready),       32'd1);
      @(negedge clk);
      #1;
      chk("flush_out_valid2", 32'(bus.out_valid),      32'd0);
      chk("flush_redirect2",  32'(bus.redirect_valid), 32'd0);
      @(negedge clk);

      // Flush with empty pipe and in_valid high: entry must not be captured
      flush         = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_kind   = 2'b10;
      bus.in_pc     = 32'hB00;
      bus.in_imm    = 32'h8;
      @(negedge clk);
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("flush_no_accept", 32'(bus.out_valid), 32'd0);
      repeat (5) @(negedge clk);

      chk("exp_q_drained",   32'(exp_q.size()),   32'd0);
      chk("redir_q_drained", 32'(redir_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Execute-side branch/jump resolution stage of the in-order core. Consumer end of the comparator interface.
- Takes decoded control-flow ops with operands, encodes funct3 into the comparator's {less, sign, negate} select, and consumes its single-bit result.
- Computes target and link, emits a one-cycle fetch redirect.
- Decoupled valid/ready on both sides; two register stages (S1 operand capture, S2 result).

Parameters:
- RESET_VECTOR, 32'h0000_0000, value of out_target/redirect_pc/out_link after reset.
- XLEN, 32, datapath width; only 32 supported.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  kill all in-flight entries (trap/mispredict from later stage)
- in_valid  input  1  upstream entry valid
- in_ready  output  1  stage can accept
- in_kind  input  2  00 none, 01 branch, 10 jal, 11 jalr
- in_funct3  input  3  branch funct3
- in_pc  input  32  instruction address
- in_rs1  input  32  operand A
- in_rs2  input  32  operand B
- in_imm  input  32  sign-extended immediate
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- out_taken  output  1  control transfer taken
- out_target  output  32  computed target
- out_link  output  32  pc+4
- out_misaligned  output  1  taken target with bit1 set
- out_illegal  output  1  branch with funct3 010/011
- redirect_valid  output  1  one-cycle fetch redirect pulse
- redirect_pc  output  32  redirect address

Behaviour:
- Reset (sync, high): s1_valid=0, out_valid=0, redirect_valid=0. out_taken/out_misaligned/out_illegal=0. out_target=redirect_pc=out_link=RESET_VECTOR.
- Accept: in_valid & in_ready at edge loads S1.
- S1 advance condition: s1_valid & (!out_valid | out_ready).
- in_ready = !redirect_valid & (!s1_valid | (advance & !s1_taken_ok)), where s1_taken_ok = taken & !misaligned.
  - A redirecting entry blocks acceptance on its advance edge and during the redirect cycle, so no younger entry is captured.
- Latency: accept at edge N -> out_valid at edge N+1 (if output free). redirect_valid high during the cycle after N+1 only.
- Comparator select from S1 funct3:
  - less = funct3[2]; sign = !funct3[1]; negate = funct3[0].
  - BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
  - 010/011 with kind=01: out_illegal=1, out_taken=0, no redirect.
- taken:
  - branch: comparator result;
  - jal, jalr: 1;
  - none: 0.
- target:
  - branch/jal: pc+imm, mod 2^32;
  - jalr: (rs1+imm) & ~1;
  - none: pc+4.
  - Wrap-around: e.g. pc=FFFF_FFFC, imm=8 -> 0000_0004.
- out_link = pc+4, mod 2^32.
- out_misaligned = taken & target[1]. A misaligned entry still presents out_taken=1 but produces no redirect.
- Redirect: on advance of an S1 entry with s1_taken_ok, the next cycle has redirect_valid=1 and redirect_pc=target. Deasserts the following cycle regardless of out_ready.
- Output hold: out_* stable while out_valid & !out_ready.
- flush (priority over everything but reset): next edge s1_valid=0, out_valid=0, redirect_valid=0. Input is not accepted on a flush edge. Data regs may keep stale values.
- Simultaneous flush and redirect-generating advance: flush wins, no redirect.
- Back-to-back non-taken entries sustain 1/cycle throughput when out_ready=1.

Test Plan:
- Reset with in_valid=1 -> out_valid=0, redirect_valid=0, out_target=0, in_ready=1 after reset deasserts.
- Branch BLT (100), rs1=FFFF_FFFF, rs2=1, pc=100, imm=20 -> out_taken=1, out_target=120, redirect pulse 1 cycle at 120. Same with BLTU (110) -> out_taken=0, no redirect, out_link=104.
- JALR rs1=1001, imm=4 -> target=1004, link=pc+4. JAL pc=200, imm=6 -> out_misaligned=1, out_taken=1, no redirect.
- funct3=010, kind=01 -> out_illegal=1, out_taken=0. Stream of 4 BEQ not-taken with out_ready=1 -> one result per cycle. out_ready=0 for 3 cycles -> outputs held, in_ready falls once S1 full.
- Taken branch followed by continuous in_valid -> next entry not accepted until redirect_valid drops. flush asserted with S1 and S2 full -> both invalid next cycle, no redirect emitted.
